axi_lite_slave_mem: RTL



---
 rtl/axi_lite_slave_mem.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave backed by a small word-addressed register memory.
// Independent write and read channels, one outstanding transaction each.
module axi_lite_slave_mem #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h50000000,
  parameter int                    DEPTH      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [2:0]              s_axi_awprot,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [2:0]              s_axi_arprot,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = {1'b0, BASE_ADDR} + (ADDR_WIDTH+1)'(4 * DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic                    active;
  logic                    aw_cap, w_cap;
  logic [ADDR_WIDTH-1:0]   aw_addr_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [DATA_WIDTH/8-1:0] w_strb_q;
  logic                    aw_hs, w_hs, ar_hs, commit;
  logic [1:0]              bresp_q, rresp_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic [ADDR_WIDTH-1:0]   aw_addr_eff, aw_off, ar_off;
  logic [DATA_WIDTH-1:0]   w_data_eff;
  logic [DATA_WIDTH/8-1:0] w_strb_eff;
  logic                    aw_in_range, ar_in_range;
  logic [IDX_W-1:0]        w_idx, ar_idx;
  logic                    unused_bits;

  // Whichever half arrived first is replayed from its holding register.
  assign aw_addr_eff = aw_cap ? aw_addr_q : s_axi_awaddr;
  assign w_data_eff  = w_cap  ? w_data_q  : s_axi_wdata;
  assign w_strb_eff  = w_cap  ? w_strb_q  : s_axi_wstrb;

  assign aw_off      = aw_addr_eff - BASE_ADDR;
  assign ar_off      = s_axi_araddr - BASE_ADDR;
  assign w_idx       = aw_off[IDX_W+1:2];
  assign ar_idx      = ar_off[IDX_W+1:2];
  assign aw_in_range = (aw_addr_eff >= BASE_ADDR) && ({1'b0, aw_addr_eff} < ADDR_LIMIT);
  assign ar_in_range = (s_axi_araddr >= BASE_ADDR) && ({1'b0, s_axi_araddr} < ADDR_LIMIT);
  assign unused_bits = ^{s_axi_awprot, s_axi_arprot, aw_off, ar_off};

  // Holds all readies low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) active <= 1'b0;
    else      active <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next        = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    aw_hs         = 1'b0;
    w_hs          = 1'b0;
    commit        = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axi_awready = active && !aw_cap;
        s_axi_wready  = active && !w_cap;
        aw_hs         = s_axi_awvalid && s_axi_awready;
        w_hs          = s_axi_wvalid && s_axi_wready;
        if ((aw_cap || aw_hs) && (w_cap || w_hs)) begin
          commit = 1'b1;
          w_next = W_RESP;
        end
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next        = r_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    ar_hs         = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axi_arready = active;
        ar_hs         = s_axi_arvalid && s_axi_arready;
        if (ar_hs) r_next = R_DATA;
      end
      R_DATA: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_cap    <= 1'b0;
      w_cap     <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
    end else if (commit) begin
      aw_cap  <= 1'b0;
      w_cap   <= 1'b0;
      bresp_q <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs) begin
        aw_cap    <= 1'b1;
        aw_addr_q <= s_axi_awaddr;
      end
      if (w_hs) begin
        w_cap    <= 1'b1;
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (commit && aw_in_range) begin
      for (int i = 0; i < DATA_WIDTH/8; i++) begin
        if (w_strb_eff[i]) mem[w_idx][8*i +: 8] <= w_data_eff[8*i +: 8];
      end
    end
  end

  // Sampled with the pre-edge memory contents, so a same-edge write is not visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= ar_in_range ? mem[ar_idx] : '0;
      rresp_q <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign s_axi_bresp = bresp_q;
  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = rresp_q;

endmodule
